// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter_if
//  Description : Bundles the core-side instruction/data ports, the core stall
//                line and the unified memory bus used by unified_mem_arbiter.
//                The slave modport is the arbiter's view of these signals.
//                The master modport is the view of the core and the memory
//                that connect to the arbiter.
//  Signals     : rom_* / ram_*  core instruction / data ports
//                stall          core stall line
//                mem_*          unified single-port memory bus
//  Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic                  rom_en;
    logic [SEL_WIDTH-1:0]  rom_write_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_write_data;
    logic [DATA_WIDTH-1:0] rom_read_data;

    logic                  ram_en;
    logic [SEL_WIDTH-1:0]  ram_write_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic [DATA_WIDTH-1:0] ram_read_data;

    logic                  stall;

    logic                  mem_req;
    logic [SEL_WIDTH-1:0]  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_read_data;

    // Arbiter side
    modport slave (
        input  rom_en, rom_write_en, rom_addr, rom_write_data,
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        input  mem_ready, mem_rvalid, mem_read_data,
        output rom_read_data, ram_read_data, stall,
        output mem_req, mem_write_en, mem_addr, mem_write_data
    );

    // Core + memory side
    modport master (
        output rom_en, rom_write_en, rom_addr, rom_write_data,
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        output mem_ready, mem_rvalid, mem_read_data,
        input  rom_read_data, ram_read_data, stall,
        input  mem_req, mem_write_en, mem_addr, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter
//  Description : Serialises the core's data and instruction accesses of one
//                core cycle onto a single-port memory bus (data first, then
//                instruction). It stalls the core until both accesses finish,
//                then presents the captured read data in a one-cycle DONE
//                state.
//  Ports       : clk           clock, rising edge
//                rst           asynchronous active-high reset
//                bus           unified_mem_arbiter_if.slave (core ports,
//                              stall, memory bus)
//                stall_cycles  saturating count of cycles with stall=1
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  wire                   clk,
    input  wire                   rst,
    unified_mem_arbiter_if.slave  bus,
    output logic [31:0]           stall_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_REQ  = 3'd1,
        ST_D_WAIT = 3'd2,
        ST_I_REQ  = 3'd3,
        ST_I_WAIT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                r_state;

    // Instruction-port snapshot. The data-port snapshot is loaded straight
    // into the bus output registers, because the data access always goes
    // out first.
    logic                  r_rom_en;
    logic [SEL_WIDTH-1:0]  r_rom_write_en;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [DATA_WIDTH-1:0] r_rom_write_data;

    logic                  r_mem_req;
    logic [SEL_WIDTH-1:0]  r_mem_write_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_write_data;

    logic [DATA_WIDTH-1:0] r_rom_read_data;
    logic [DATA_WIDTH-1:0] r_ram_read_data;
    logic [31:0]           r_stall_cycles;

    logic                  w_any_en;
    logic                  w_stall;

    assign w_any_en = bus.rom_en | bus.ram_en;

    // Stall also falls during reset, so the core sees every output at 0.
    assign w_stall = !rst &&
                     ((r_state == ST_D_REQ)  || (r_state == ST_D_WAIT) ||
                      (r_state == ST_I_REQ)  || (r_state == ST_I_WAIT) ||
                      ((r_state == ST_IDLE) && w_any_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_rom_en         <= 1'b0;
            r_rom_write_en   <= '0;
            r_rom_addr       <= '0;
            r_rom_write_data <= '0;
            r_mem_req        <= 1'b0;
            r_mem_write_en   <= '0;
            r_mem_addr       <= '0;
            r_mem_write_data <= '0;
            r_rom_read_data  <= '0;
            r_ram_read_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_en) begin
                        r_rom_en         <= bus.rom_en;
                        r_rom_write_en   <= bus.rom_write_en;
                        r_rom_addr       <= bus.rom_addr;
                        r_rom_write_data <= bus.rom_write_data;
                        r_mem_req        <= 1'b1;
                        if (bus.ram_en) begin
                            r_state          <= ST_D_REQ;
                            r_mem_write_en   <= bus.ram_write_en;
                            r_mem_addr       <= bus.ram_addr;
                            r_mem_write_data <= bus.ram_write_data;
                        end else begin
                            r_state          <= ST_I_REQ;
                            r_mem_write_en   <= bus.rom_write_en;
                            r_mem_addr       <= bus.rom_addr;
                            r_mem_write_data <= bus.rom_write_data;
                        end
                    end
                end

                ST_D_REQ: begin
                    if (bus.mem_ready) begin
                        // A store that hands straight over to the fetch keeps
                        // mem_req high and just swaps in the fetch fields.
                        if ((r_mem_write_en == '0) || !r_rom_en) begin
                            r_state          <= (r_mem_write_en == '0) ? ST_D_WAIT : ST_DONE;
                            r_mem_req        <= 1'b0;
                            r_mem_write_en   <= '0;
                            r_mem_addr       <= '0;
                            r_mem_write_data <= '0;
                        end else begin
                            r_state          <= ST_I_REQ;
                            r_mem_write_en   <= r_rom_write_en;
                            r_mem_addr       <= r_rom_addr;
                            r_mem_write_data <= r_rom_write_data;
                        end
                    end
                end

                ST_D_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_ram_read_data <= bus.mem_read_data;
                        if (r_rom_en) begin
                            r_state          <= ST_I_REQ;
                            r_mem_req        <= 1'b1;
                            r_mem_write_en   <= r_rom_write_en;
                            r_mem_addr       <= r_rom_addr;
                            r_mem_write_data <= r_rom_write_data;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_I_REQ: begin
                    if (bus.mem_ready) begin
                        r_state          <= (r_mem_write_en == '0) ? ST_I_WAIT : ST_DONE;
                        r_mem_req        <= 1'b0;
                        r_mem_write_en   <= '0;
                        r_mem_addr       <= '0;
                        r_mem_write_data <= '0;
                    end
                end

                ST_I_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_rom_read_data <= bus.mem_read_data;
                        r_state         <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state          <= ST_IDLE;
                    r_mem_req        <= 1'b0;
                    r_mem_write_en   <= '0;
                    r_mem_addr       <= '0;
                    r_mem_write_data <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall          = w_stall;
    assign bus.mem_req        = r_mem_req;
    assign bus.mem_write_en   = r_mem_write_en;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_write_data = r_mem_write_data;
    assign bus.rom_read_data  = r_rom_read_data;
    assign bus.ram_read_data  = r_ram_read_data;
    assign stall_cycles       = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_mem_arbiter
//  Description : Testbench for unified_mem_arbiter. A core driver issues
//                directed and random transactions. A memory model answers
//                the bus with per-access ready/rvalid delays, and an
//                independent monitor checks bus requests and DONE-cycle
//                results against queued expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cycles;

    unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) u_if ();

    unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (u_if.slave),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wd; } bus_t;
    typedef struct { int rdy; int rv; } dly_t;
    typedef struct { logic [31:0] ram; logic [31:0] rom; int stalls; } done_t;

    bus_t  q_bus[$];
    dly_t  q_dly[$];
    done_t q_done[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the read-data outputs
    logic [31:0] m_ram = 32'd0;
    logic [31:0] m_rom = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory model (drives bus responses at negedge) -------
    bit          rd_pending = 1'b0;
    bit          cfg_ok     = 1'b0;
    int          rdy_left   = 0;
    int          rv_left    = 0;
    logic [31:0] rd_addr, last_addr, last_wd;
    logic [3:0]  last_we;

    initial begin
        u_if.mem_ready     = 1'b0;
        u_if.mem_rvalid    = 1'b0;
        u_if.mem_read_data = '0;
        forever begin
            @(negedge clk);
            u_if.mem_ready     = 1'b0;
            u_if.mem_rvalid    = 1'b0;
            u_if.mem_read_data = $urandom();
            if (rst) begin
                rd_pending = 1'b0;
                cfg_ok     = 1'b0;
            end else if (rd_pending) begin
                if (u_if.mem_req) check("no_overlap_req", 32'(u_if.mem_req), 32'd0);
                if (rv_left == 0) begin
                    u_if.mem_rvalid    = 1'b1;
                    u_if.mem_read_data = rd_val(rd_addr);
                    rd_pending         = 1'b0;
                end else begin
                    rv_left--;
                end
            end else if (u_if.mem_req) begin
                if (!cfg_ok) begin
                    if (q_dly.size() == 0) begin
                        check("delay_cfg_available", 32'd0, 32'd1);
                        rdy_left = 0;
                        rv_left  = 0;
                    end else begin
                        dly_t d;
                        d        = q_dly.pop_front();
                        rdy_left = d.rdy;
                        rv_left  = d.rv;
                    end
                    cfg_ok = 1'b1;
                end else begin
                    check("req_stable_addr", u_if.mem_addr, last_addr);
                    check("req_stable_we", 32'(u_if.mem_write_en), 32'(last_we));
                    check("req_stable_wd", u_if.mem_write_data, last_wd);
                end
                last_addr = u_if.mem_addr;
                last_we   = u_if.mem_write_en;
                last_wd   = u_if.mem_write_data;
                if (rdy_left == 0) begin
                    u_if.mem_ready = 1'b1;
                    cfg_ok         = 1'b0;
                    if (u_if.mem_write_en == 4'd0) begin
                        rd_pending = 1'b1;
                        rd_addr    = u_if.mem_addr;
                    end
                end else begin
                    rdy_left--;
                end
            end
        end
    end

    // ---------------- monitor (negedge + 1) --------------------------------
    bit          prev_stall = 1'b0;
    logic [31:0] st_start   = 32'd0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (u_if.mem_req && u_if.mem_ready) begin
                    if (q_bus.size() == 0) begin
                        check("unexpected_bus_req", u_if.mem_addr, 32'hDEAD_DEAD);
                    end else begin
                        bus_t b;
                        b = q_bus.pop_front();
                        check("bus_addr", u_if.mem_addr, b.addr);
                        check("bus_we", 32'(u_if.mem_write_en), 32'(b.we));
                        if (b.we != 4'd0) check("bus_wdata", u_if.mem_write_data, b.wd);
                    end
                end
                if (!u_if.mem_req) begin
                    check("bus_idle_zero",
                          u_if.mem_addr | u_if.mem_write_data | 32'(u_if.mem_write_en), 32'd0);
                end
                if (!prev_stall && u_if.stall) st_start = stall_cycles;
                if (prev_stall && !u_if.stall) begin
                    if (q_done.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        done_t e;
                        e = q_done.pop_front();
                        check("done_ram_read_data", u_if.ram_read_data, e.ram);
                        check("done_rom_read_data", u_if.rom_read_data, e.rom);
                        check("done_stall_delta", stall_cycles - st_start, 32'(e.stalls));
                    end
                end
                prev_stall = u_if.stall;
            end
        end
    end

    // ---------------- driver ------------------------------------------------
    task automatic run_txn(input bit ren, input logic [3:0] rwe, input logic [31:0] ra,
                           input logic [31:0] rwd, input bit ien, input logic [3:0] iwe,
                           input logic [31:0] ia, input logic [31:0] iwd,
                           input int d0r, input int d0v, input int d1r, input int d1v);
        done_t e;
        int    exp_st;
        int    cyc;
        exp_st = 1;
        if (ren) begin
            q_bus.push_back('{ra, rwe, rwd});
            q_dly.push_back('{d0r, d0v});
            exp_st += d0r + 1 + ((rwe == 4'd0) ? d0v + 1 : 0);
            if (rwe == 4'd0) m_ram = rd_val(ra);
        end
        if (ien) begin
            q_bus.push_back('{ia, iwe, iwd});
            q_dly.push_back('{d1r, d1v});
            exp_st += d1r + 1 + ((iwe == 4'd0) ? d1v + 1 : 0);
            if (iwe == 4'd0) m_rom = rd_val(ia);
        end
        e.ram    = m_ram;
        e.rom    = m_rom;
        e.stalls = exp_st;
        q_done.push_back(e);

        @(posedge clk);
        #1;
        u_if.ram_en         = ren;
        u_if.ram_write_en   = rwe;
        u_if.ram_addr       = ra;
        u_if.ram_write_data = rwd;
        u_if.rom_en         = ien;
        u_if.rom_write_en   = iwe;
        u_if.rom_addr       = ia;
        u_if.rom_write_data = iwd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (u_if.stall && cyc < 300);
        check("txn_cycles", 32'(cyc), 32'(exp_st + 1));
    endtask

    task automatic idle_cycles(input int n);
        logic [31:0] sc;
        @(posedge clk);
        #1;
        u_if.ram_en = 1'b0;
        u_if.rom_en = 1'b0;
        @(negedge clk);
        sc = stall_cycles;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_stall", 32'(u_if.stall), 32'd0);
            check("idle_mem_req", 32'(u_if.mem_req), 32'd0);
            check("idle_stall_cycles", stall_cycles, sc);
        end
    endtask

    initial begin
        int          guard;
        bit          ren, ien;
        logic [3:0]  rwe, iwe;

        rst                 = 1'b1;
        u_if.rom_en         = 1'b0;
        u_if.rom_write_en   = '0;
        u_if.rom_addr       = '0;
        u_if.rom_write_data = '0;
        u_if.ram_en         = 1'b0;
        u_if.ram_write_en   = '0;
        u_if.ram_addr       = '0;
        u_if.ram_write_data = '0;

        repeat (3) @(negedge clk);
        check("rst_stall", 32'(u_if.stall), 32'd0);
        check("rst_mem_req", 32'(u_if.mem_req), 32'd0);
        check("rst_mem_bus", u_if.mem_addr | u_if.mem_write_data | 32'(u_if.mem_write_en), 32'd0);
        check("rst_rom_rd", u_if.rom_read_data, 32'd0);
        check("rst_ram_rd", u_if.ram_read_data, 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        #2 rst = 1'b0;

        // Fetch only: 3 stall cycles, 4 total
        run_txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'hBFC0_0000, 32'd0, 0, 0, 0, 0);
        // Load + fetch: 6 cycles
        run_txn(1'b1, 4'd0, 32'h8000_0010, 32'd0, 1'b1, 4'd0, 32'hBFC0_0004, 32'd0, 0, 0, 0, 0);
        // Store + fetch: 5 cycles, ram read data kept
        run_txn(1'b1, 4'b0011, 32'h8000_0020, 32'h0000_BEEF, 1'b1, 4'd0, 32'hBFC0_0008, 32'd0, 0, 0, 0, 0);
        // Data read only (4 cycles) and data write only (3 cycles)
        run_txn(1'b1, 4'd0, 32'h8000_0030, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        run_txn(1'b1, 4'b1111, 32'h8000_0034, 32'h1234_5678, 1'b0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        // Backpressure: 3 not-ready cycles, rvalid 2 cycles late -> 8 stalls
        run_txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'hBFC0_000C, 32'd0, 0, 0, 3, 2);

        idle_cycles(10);

        for (int i = 0; i < 40; i++) begin
            ren = 1'($urandom_range(0, 1));
            ien = 1'($urandom_range(0, 1));
            if (!ren && !ien) ien = 1'b1;
            rwe = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            iwe = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            run_txn(ren, rwe, $urandom() & 32'hFFFF_FFFC, $urandom(),
                    ien, iwe, $urandom() & 32'hFFFF_FFFC, $urandom(),
                    $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) idle_cycles(2);
        end

        // Reset while the data read waits for rvalid
        q_bus.push_back('{32'h8000_0040, 4'd0, 32'd0});
        q_dly.push_back('{0, 6});
        @(posedge clk);
        #1;
        u_if.ram_en       = 1'b1;
        u_if.ram_write_en = 4'd0;
        u_if.ram_addr     = 32'h8000_0040;
        u_if.rom_en       = 1'b1;
        u_if.rom_write_en = 4'd0;
        u_if.rom_addr     = 32'hBFC0_0010;
        guard = 0;
        do begin
            @(negedge clk);
            #2;
            guard++;
        end while (!rd_pending && guard < 20);
        check("reached_d_wait", 32'(rd_pending), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_mem_req", 32'(u_if.mem_req), 32'd0);
        check("async_rst_stall", 32'(u_if.stall), 32'd0);
        check("async_rst_ram_rd", u_if.ram_read_data, 32'd0);
        check("async_rst_rom_rd", u_if.rom_read_data, 32'd0);
        check("async_rst_stall_cycles", stall_cycles, 32'd0);
        q_bus.delete();
        q_dly.delete();
        q_done.delete();
        m_ram       = 32'd0;
        m_rom       = 32'd0;
        u_if.ram_en = 1'b0;
        u_if.rom_en = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;

        idle_cycles(10);

        // One more fetch after reset to confirm normal operation
        run_txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'hBFC0_0000, 32'd0, 1, 1, 0, 0);
        idle_cycles(2);

        if (q_bus.size() != 0 || q_done.size() != 0)
            check("queues_drained", 32'(q_bus.size() + q_done.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port memory bus between the core's instruction port (rom_*) and data port (ram_*). The block serialises the two requests of each core cycle onto the memory bus, serving data first and then instruction. It holds the core's `stall` input asserted until both accesses complete, then presents captured read data for exactly one cycle. It sits between the core and the unified SRAM/bus bridge at SoC top level.

## Interface
- `ADDR_WIDTH`, default 32: address width of all ports.
- `DATA_WIDTH`, default 32: data width of all ports.
- `SEL_WIDTH`, default 4: byte-enable width, DATA_WIDTH/8.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rom_en` in 1: instruction port request.
- `rom_write_en` in SEL_WIDTH: instruction port byte write enables; 0 means read.
- `rom_addr` in ADDR_WIDTH: instruction port address.
- `rom_write_data` in DATA_WIDTH: instruction port write data.
- `rom_read_data` out DATA_WIDTH: captured instruction read data.
- `ram_en`, `ram_write_en`, `ram_addr`, `ram_write_data`, `ram_read_data`: data port, same widths and meanings as the rom_* ports.
- `stall` out 1: to core stall input; the core advances only in cycles where this is 0.
- `mem_req` out 1: bus request valid.
- `mem_write_en` out SEL_WIDTH: bus byte enables; 0 means read.
- `mem_addr` out ADDR_WIDTH: bus address.
- `mem_write_data` out DATA_WIDTH: bus write data.
- `mem_ready` in 1: bus accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_read_data` in DATA_WIDTH: bus read data.
- `stall_cycles` out 32: count of cycles with stall=1, saturating.

## Operation
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
- IDLE, no request (rom_en=0 and ram_en=0): stay in IDLE; stall=0.
- IDLE, either enable set:
  - Snapshot en, write_en, addr and write_data of both ports into registers.
  - Go to D_REQ if ram_en=1, else I_REQ.
  - stall=1.
- D_REQ / I_REQ:
  - mem_req=1 with the snapshot of that port.
  - mem_write_en = snapshot write_en.
  - Hold until mem_ready=1.
  - On accept: read goes to the matching *_WAIT; write skips it.
  - Exit from D_REQ/D_WAIT goes to I_REQ if the rom snapshot en=1, else DONE.
  - Exit from I_REQ/I_WAIT goes to DONE.
- D_WAIT / I_WAIT:
  - Hold until mem_rvalid=1.
  - Then load mem_read_data into ram_read_data or rom_read_data.
- DONE: stall=0 for exactly one cycle, then IDLE.
- Output signals when not in a REQ state: mem_req=0; mem_addr, mem_write_en and mem_write_data=0.
- mem_rvalid is sampled only in WAIT states; otherwise it is ignored.
- The memory guarantees mem_rvalid no earlier than the cycle after accept.
- Read-data registers keep their previous value when their port was not read in the transaction, or was written.
- stall is combinational from state and inputs:
  - stall=1 in D_REQ, D_WAIT, I_REQ and I_WAIT.
  - stall=1 in IDLE when either enable is set.
  - stall=0 otherwise.
- stall_cycles increments on every cycle with stall=1 and saturates at 0xFFFFFFFF.
- Reset (async, any state):
  - State returns to IDLE.
  - mem_req drops immediately.
  - All registers and outputs are 0.
  - The bus is reset by the same rst; abandoned transactions produce no later rvalid.

## Timing
- Reset values: stall=0, mem_req=0, mem_* outputs=0, rom_read_data=0, ram_read_data=0, stall_cycles=0.
- Cycle counts with mem_ready tied 1 and rvalid one cycle after accept:
  - Fetch only: 4 cycles (IDLE, I_REQ, I_WAIT, DONE); stall=1 for 3 of them.
  - Load + fetch: 6 cycles.
  - Store + fetch: 5 cycles.
  - Data port only: 4 cycles for a read, 3 for a write.
- Each extra cycle of mem_ready=0 or late rvalid adds one stall cycle.
- Read data is valid in the DONE cycle and is held stable afterwards.
- Data access is always issued before instruction access within one transaction.
- No two requests are ever outstanding at once.

## Test plan
- Fetch only: rom_en=1, addr 0xBFC00000, bus returns 0x24080001 one cycle after accept.
  - Required: stall 1,1,1,0.
  - Required: rom_read_data=0x24080001 in the DONE cycle.
  - Required: mem_addr=0xBFC00000 during I_REQ.
- Load + fetch: ram_en=1, ram_addr 0x80000010; rom_addr 0xBFC00004.
  - Required: first bus request is 0x80000010 (read), second is 0xBFC00004.
  - Required: 6-cycle transaction; both read-data outputs are correct in DONE.
- Store: ram_write_en=4'b0011, data 0x0000BEEF.
  - Required: mem_write_en=0011 and no D_WAIT.
  - Required: ram_read_data unchanged from its previous value.
- Backpressure: mem_ready=0 for 3 cycles in I_REQ, then rvalid delayed 2 cycles.
  - Required: mem_req and mem_addr stable throughout.
  - Required: stall extends by 5 cycles; stall_cycles increases by 8.
- Reset in D_WAIT: assert rst mid-cycle.
  - Required: mem_req, stall and read data go 0 without waiting for a clock edge.
  - Required: after release with no enables, FSM sits in IDLE with stall=0.
- Idle: rom_en=ram_en=0 for 10 cycles.
  - Required: stall=0, mem_req=0, stall_cycles unchanged.
